pipe_ctrl: RTL

- Central pipeline controller for the 5-stage CPU (pc, if/id, id/ex, ex/mem, mem/wb, wb).
- Resolves stall requests from the id, ex and mem stages into a per-stage stall vector.
- Sequences exception/eret flushes, drives the redirect PC to the pc stage, and masks new exceptions during a post-flush recovery window.
- Every pipeline register, including mem_wb, consumes its stall bit and the flush signal from this block.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_if.sv | 28 ++
 rtl/pipe_ctrl_stall_wdt.sv | 36 +++
 rtl/pipe_ctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: stall vectors, FSM states, bus widths.
package pipe_ctrl_pkg;

    localparam int INST_ADDR_W = 32;
    localparam logic [INST_ADDR_W-1:0] ZERO_WORD = 32'h0000_0000;

    // bit0 pc, bit1 if/id, bit2 id/ex, bit3 ex/mem, bit4 mem/wb, bit5 wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        CTRL_RUN     = 2'd0,
        CTRL_FLUSH   = 2'd1,
        CTRL_RECOVER = 2'd2
    } ctrl_state_t;

    // The stage furthest down the pipe wins, since it freezes everything behind it.
    function automatic logic [5:0] stall_encode(input logic req_id, input logic req_ex,
                                                input logic req_mem);
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Controller <-> pipeline bundle: stall requests, exception handshake, stall/flush/redirect.
// Handshake: excp_valid is held with a stable excp_pc until excp_ack pulses in the same
// cycle; the transfer completes on that clock edge and the source may then drop or change them.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   stallreq_id;
    logic                   stallreq_ex;
    logic                   stallreq_mem;
    logic                   excp_valid;
    logic [INST_ADDR_W-1:0] excp_pc;
    logic                   excp_ack;
    logic [5:0]             stall;
    logic                   flush;
    logic [INST_ADDR_W-1:0] new_pc;
    logic                   stall_timeout;

    modport master (
        input  stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_pc,
        output excp_ack, stall, flush, new_pc, stall_timeout
    );

    modport slave (
        output stallreq_id, stallreq_ex, stallreq_mem, excp_valid, excp_pc,
        input  excp_ack, stall, flush, new_pc, stall_timeout
    );

endinterface

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall watchdog: counts consecutive stalled cycles and raises a sticky timeout flag.
module pipe_ctrl_stall_wdt #(
    parameter int WDT_LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic stall_timeout
);
    localparam int CNT_W = $clog2(WDT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WDT_LIMIT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt = cnt;
        if (!stall_active)
            cnt_nxt = '0;
        else if (cnt != LIMIT)
            cnt_nxt = cnt + 1'b1;
    end

    // Flag rises on the same edge the counter reaches the limit, then sticks until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            stall_timeout <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (cnt_nxt == LIMIT)
                stall_timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall resolution, exception flush sequencing and post-flush recovery.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RECOVER_CYCLES = 2,
    parameter int WDT_LIMIT      = 1024
) (
    input  logic          clk,
    input  logic          rst,
    pipe_ctrl_if.master   bus,
    output ctrl_state_t   dbg_state
);
    localparam int RC_W = $clog2(RECOVER_CYCLES + 2);

    ctrl_state_t            state, state_nxt;
    logic                   flush_q, flush_nxt;
    logic [INST_ADDR_W-1:0] new_pc_q, new_pc_nxt;
    logic [RC_W-1:0]        rc_cnt, rc_nxt;
    logic                   ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CTRL_RUN;
            flush_q  <= 1'b0;
            new_pc_q <= ZERO_WORD;
            rc_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            flush_q  <= flush_nxt;
            new_pc_q <= new_pc_nxt;
            rc_cnt   <= rc_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        flush_nxt  = 1'b0;
        new_pc_nxt = new_pc_q;
        rc_nxt     = rc_cnt;
        ack        = 1'b0;
        case (state)
            CTRL_RUN: begin
                // A pending memory wait must finish before the pipe can be flushed.
                if (bus.excp_valid && !bus.stallreq_mem) begin
                    ack        = 1'b1;
                    flush_nxt  = 1'b1;
                    new_pc_nxt = bus.excp_pc;
                    state_nxt  = CTRL_FLUSH;
                end
            end
            CTRL_FLUSH: begin
                if (RECOVER_CYCLES > 0) begin
                    rc_nxt    = RC_W'(RECOVER_CYCLES - 1);
                    state_nxt = CTRL_RECOVER;
                end else begin
                    state_nxt = CTRL_RUN;
                end
            end
            CTRL_RECOVER: begin
                if (rc_cnt == '0)
                    state_nxt = CTRL_RUN;
                else
                    rc_nxt = rc_cnt - 1'b1;
            end
            default: state_nxt = CTRL_RUN;
        endcase
    end

    assign bus.excp_ack = ack & ~rst;
    assign bus.flush    = flush_q;
    assign bus.new_pc   = new_pc_q;
    assign bus.stall    = (rst || state == CTRL_FLUSH) ? STALL_NONE
                        : stall_encode(bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
    assign dbg_state    = state;

`ifdef PIPE_CTRL_STALL_WDT_EN
    pipe_ctrl_stall_wdt #(
        .WDT_LIMIT (WDT_LIMIT)
    ) u_stall_wdt (
        .clk           (clk),
        .rst           (rst),
        .stall_active  (bus.stall != STALL_NONE),
        .stall_timeout (bus.stall_timeout)
    );
`else
    assign bus.stall_timeout = 1'b0;
`endif

endmodule
